// File: rtl/tmds_word_if.sv
// Decoded-word bus of one TMDS receive lane.
// The decoder drives it (master); downstream pixel logic consumes it (slave).
interface tmds_word_if;
    logic       out_valid;
    logic       out_de;
    logic [1:0] out_ctrl;
    logic [7:0] out_data;
    logic       locked;
    logic [3:0] bit_offset;

    modport master (
        output out_valid,
        output out_de,
        output out_ctrl,
        output out_data,
        output locked,
        output bit_offset
    );

    modport slave (
        input out_valid,
        input out_de,
        input out_ctrl,
        input out_data,
        input locked,
        input bit_offset
    );
endinterface

// File: rtl/tmds_word_decoder.sv
// TMDS lane receiver: 2 bits/clk in, word alignment via control-token
// runs, 10b->8b decode with lock tracking. One instance per lane.
module tmds_word_decoder #(
    parameter int CTRL_RUN     = 8,
    parameter int SEARCH_WORDS = 2048,
    parameter int LOSS_WORDS   = 4096
) (
    input  logic        clk_shift,
    input  logic        rst_n,
    input  logic [1:0]  din,
    tmds_word_if.master tif
);

    localparam int RW = $clog2(CTRL_RUN + 1);
    localparam int SW = $clog2(SEARCH_WORDS + 1);
    localparam int LW = $clog2(LOSS_WORDS + 1);

    localparam logic [RW-1:0] RUN_LAST  = RW'(CTRL_RUN - 1);
    localparam logic [SW-1:0] SRCH_LAST = SW'(SEARCH_WORDS - 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_WORDS - 1);

    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] TOK11 = 10'b1010101011;

    typedef enum logic {
        S_SEARCH,
        S_LOCKED
    } state_t;

    state_t        state_q;
    logic [19:0]   sr_q, sr_d;
    logic [2:0]    phase_q, phase_d;
    logic [3:0]    off_q;
    logic [RW-1:0] run_q;
    logic [SW-1:0] srch_q;
    logic [LW-1:0] loss_q;

    logic          valid_q;
    logic          de_q;
    logic [1:0]    ctrl_q;
    logic [7:0]    data_q;

    logic          strobe;
    logic [9:0]    w;
    logic          is_ctrl;
    logic [1:0]    tok;
    logic [7:0]    dm;
    logic [7:0]    dec;

    // Newest pair enters at the top; sr_q[0] is the oldest bit.
    assign sr_d    = {din, sr_q[19:2]};
    assign phase_d = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
    assign strobe  = (phase_q == 3'd4);

    always_comb begin
        w = '0;
        for (int k = 0; k < 10; k++) begin
            if (off_q == k[3:0]) begin
                w = sr_q[k +: 10];
            end
        end
    end

    always_comb begin
        is_ctrl = 1'b1;
        tok     = 2'b00;
        unique case (1'b1)
            (w == TOK00): tok = 2'b00;
            (w == TOK01): tok = 2'b01;
            (w == TOK10): tok = 2'b10;
            (w == TOK11): tok = 2'b11;
            default:      is_ctrl = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR chain.
    always_comb begin
        dm     = w[9] ? ~w[7:0] : w[7:0];
        dec    = '0;
        dec[0] = dm[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = w[8] ? (dm[i] ^ dm[i-1]) : ~(dm[i] ^ dm[i-1]);
        end
    end

    always_ff @(posedge clk_shift or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= '0;
            phase_q <= '0;
        end else begin
            sr_q    <= sr_d;
            phase_q <= phase_d;
        end
    end

    // Alignment FSM; out_valid reflects the state after this word.
    always_ff @(posedge clk_shift or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_SEARCH;
            off_q   <= '0;
            run_q   <= '0;
            srch_q  <= '0;
            loss_q  <= '0;
            valid_q <= 1'b0;
            de_q    <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            if (strobe) begin
                de_q   <= ~is_ctrl;
                data_q <= is_ctrl ? 8'h00 : dec;
                if (is_ctrl) begin
                    ctrl_q <= tok;
                end
                unique case (state_q)
                    S_SEARCH: begin
                        if (is_ctrl && run_q == RUN_LAST) begin
                            state_q <= S_LOCKED;
                            run_q   <= '0;
                            srch_q  <= '0;
                            loss_q  <= '0;
                            valid_q <= 1'b1;
                        end else if (srch_q == SRCH_LAST) begin
                            off_q  <= (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
                            run_q  <= '0;
                            srch_q <= '0;
                        end else begin
                            run_q  <= is_ctrl ? run_q + 1'b1 : '0;
                            srch_q <= srch_q + 1'b1;
                        end
                    end
                    S_LOCKED: begin
                        if (is_ctrl) begin
                            loss_q  <= '0;
                            valid_q <= 1'b1;
                        end else if (loss_q == LOSS_LAST) begin
                            state_q <= S_SEARCH;
                            run_q   <= '0;
                            srch_q  <= '0;
                            loss_q  <= '0;
                        end else begin
                            loss_q  <= loss_q + 1'b1;
                            valid_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_SEARCH;
                endcase
            end
        end
    end

    assign tif.out_valid  = valid_q;
    assign tif.out_de     = de_q;
    assign tif.out_ctrl   = ctrl_q;
    assign tif.out_data   = data_q;
    assign tif.locked     = (state_q == S_LOCKED);
    assign tif.bit_offset = off_q;

endmodule

// File: tb/tb_tmds_word_decoder.sv
// Directed bench for tmds_word_decoder: decode table, lock, search,
// wrap, loss/relock and lock/slip coincidence.
module tb_tmds_word_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] din;

    tmds_word_if tif ();

    tmds_word_decoder #(
        .CTRL_RUN    (8),
        .SEARCH_WORDS(16),
        .LOSS_WORDS  (32)
    ) dut (
        .clk_shift(clk),
        .rst_n    (rst_n),
        .din      (din),
        .tif      (tif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] w;
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
    } vec_t;

    typedef struct {
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
        logic       locked;
        int         cyc;
    } pulse_t;

    vec_t   tbl[11];
    pulse_t pq[$];
    bit     bq[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc;
    int     lock_cyc;
    int     unlocks;
    logic   saw9;
    logic   lk_prev;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [9:0] wd);
        for (int i = 0; i < 10; i++) bq.push_back(wd[i]);
    endtask

    task automatic push_pad(input int n);
        for (int i = 0; i < n; i++) bq.push_back(1'b0);
    endtask

    task automatic tick();
        bit b0, b1;
        b0 = 1'b0;
        b1 = 1'b0;
        if (bq.size() > 0) b0 = bq.pop_front();
        if (bq.size() > 0) b1 = bq.pop_front();
        din = {b1, b0};
        @(negedge clk);
        cyc++;
        if (tif.out_valid)
            pq.push_back('{tif.out_de, tif.out_ctrl, tif.out_data,
                           tif.locked, cyc});
        if (tif.locked && !lk_prev && lock_cyc < 0) lock_cyc = cyc;
        if (!tif.locked && lk_prev) unlocks++;
        if (tif.bit_offset == 4'd9) saw9 = 1'b1;
        lk_prev = tif.locked;
    endtask

    task automatic start();
        @(negedge clk);
        rst_n = 1'b0;
        bq.delete();
        pq.delete();
        cyc      = 0;
        lock_cyc = -1;
        unlocks  = 0;
        saw9     = 1'b0;
        lk_prev  = 1'b0;
        repeat (3) begin
            din = 2'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic drain();
        while (bq.size() > 0) tick();
        repeat (10) tick();
    endtask

    initial begin
        int idx;
        int nd;
        logic dok;

        tbl[0]  = '{10'h09C, 1'b1, 2'b00, 8'h5A};
        tbl[1]  = '{10'h263, 1'b1, 2'b00, 8'h5A};
        tbl[2]  = '{10'h0AB, 1'b0, 2'b01, 8'h00};
        tbl[3]  = '{10'h100, 1'b1, 2'b01, 8'h00};
        tbl[4]  = '{10'h2AB, 1'b0, 2'b11, 8'h00};
        tbl[5]  = '{10'h200, 1'b1, 2'b11, 8'hFF};
        tbl[6]  = '{10'h1FF, 1'b1, 2'b11, 8'h01};
        tbl[7]  = '{10'h154, 1'b0, 2'b10, 8'h00};
        tbl[8]  = '{10'h30F, 1'b1, 2'b10, 8'h10};
        tbl[9]  = '{10'h354, 1'b0, 2'b00, 8'h00};
        tbl[10] = '{10'h000, 1'b1, 2'b00, 8'hFE};

        rst_n = 1'b0;
        din   = 2'b00;

        // Reset values, then an idle stream must not produce pulses.
        start();
        chk("rst_valid",  32'(tif.out_valid),  0);
        chk("rst_de",     32'(tif.out_de),     0);
        chk("rst_ctrl",   32'(tif.out_ctrl),   0);
        chk("rst_data",   32'(tif.out_data),   0);
        chk("rst_locked", 32'(tif.locked),     0);
        chk("rst_offset", 32'(tif.bit_offset), 0);
        rst_n = 1'b1;
        repeat (30) tick();
        chk("idle_pulses", 32'(pq.size()), 0);
        chk("idle_locked", 32'(tif.locked), 0);

        // Aligned lock at offset 0, then the decode table.
        start();
        push_pad(8);
        repeat (8) push_word(10'h354);
        foreach (tbl[i]) push_word(tbl[i].w);
        rst_n = 1'b1;
        drain();
        chk("al_lock_cyc", 32'(lock_cyc), 50);
        chk("al_offset", 32'(tif.bit_offset), 0);
        chk("al_npulse", 32'(pq.size() >= 12), 1);
        if (pq.size() >= 12) begin
            chk("al_first_de", 32'(pq[0].de), 0);
            chk("al_first_ctrl", 32'(pq[0].ctrl), 0);
            chk("al_first_lk", 32'(pq[0].locked), 1);
            chk("al_first_cyc", 32'(pq[0].cyc), 32'(lock_cyc));
            chk("al_period", 32'(pq[1].cyc - pq[0].cyc), 5);
            for (int i = 0; i < 11; i++) begin
                chk($sformatf("tbl%0d_de", i), 32'(pq[i+1].de),
                    32'(tbl[i].de));
                chk($sformatf("tbl%0d_ctrl", i), 32'(pq[i+1].ctrl),
                    32'(tbl[i].ctrl));
                chk($sformatf("tbl%0d_data", i), 32'(pq[i+1].data),
                    32'(tbl[i].data));
            end
        end

        // Stream delayed 7 bits: search, lock, lose lock, relock.
        start();
        push_pad(15);
        repeat (150) push_word(10'h154);
        repeat (32) push_word(10'h09C);
        repeat (8) push_word(10'h154);
        rst_n = 1'b1;
        drain();
        chk("mis_offset", 32'(tif.bit_offset), 7);
        chk("mis_locked", 32'(tif.locked), 1);
        chk("mis_unlocks", 32'(unlocks), 1);
        idx = -1;
        foreach (pq[i]) if (idx < 0 && pq[i].de) idx = i;
        chk("mis_has_data", 32'(idx > 0), 1);
        if (idx > 0) begin
            chk("mis_first_de", 32'(pq[0].de), 0);
            chk("mis_first_ctrl", 32'(pq[0].ctrl), 2);
            nd  = 0;
            dok = 1'b1;
            while (idx + nd < pq.size() && pq[idx+nd].de) begin
                if (pq[idx+nd].data != 8'h5A) dok = 1'b0;
                nd++;
            end
            chk("loss_ndata", 32'(nd), 31);
            chk("loss_data", 32'(dok), 1);
            if (idx + nd < pq.size()) begin
                chk("relock_de", 32'(pq[idx+nd].de), 0);
                chk("relock_ctrl", 32'(pq[idx+nd].ctrl), 2);
            end else begin
                chk("relock_pulse", 0, 1);
            end
        end

        // Reset mid-stream clears everything immediately.
        rst_n = 1'b0;
        #1;
        chk("mid_locked", 32'(tif.locked), 0);
        chk("mid_offset", 32'(tif.bit_offset), 0);
        chk("mid_ctrl", 32'(tif.out_ctrl), 0);
        chk("mid_data", 32'(tif.out_data), 0);

        // Offset must wrap 9 -> 0 before lock.
        start();
        push_pad(8);
        repeat (20) push_word(10'h09C);
        repeat (180) push_word(10'h0AB);
        rst_n = 1'b1;
        while (!tif.locked && cyc < 1500) tick();
        chk("wrap_locked", 32'(tif.locked), 1);
        chk("wrap_saw9", 32'(saw9), 1);
        chk("wrap_offset", 32'(tif.bit_offset), 0);
        chk("wrap_lock_cyc", 32'(lock_cyc), 840);
        if (pq.size() > 0) chk("wrap_ctrl", 32'(pq[0].ctrl), 1);
        else chk("wrap_pulse", 0, 1);

        // 8th token on the last search word: lock, no slip.
        start();
        push_pad(8);
        repeat (6) push_word(10'h09C);
        repeat (20) push_word(10'h354);
        rst_n = 1'b1;
        while (!tif.locked && cyc < 200) tick();
        repeat (3) tick();
        chk("coin_locked", 32'(tif.locked), 1);
        chk("coin_offset", 32'(tif.bit_offset), 0);
        chk("coin_lock_cyc", 32'(lock_cyc), 80);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
